// File: rtl/seg7_pkg.sv
// seg7_pkg: definitions shared by the seven-segment encoder and the scan decoder.
//   seg7_pattern_t : 7-bit active-low segment pattern, bit0=a ... bit6=g
//   SEG7_PATTERNS  : active-low pattern for each hex nibble 0..F
//   seg7_decode    : pattern -> {valid, nibble}
//   frame_state_t  : frame assembly FSM states of the scan decoder
package seg7_pkg;

  typedef logic [6:0] seg7_pattern_t;

  localparam seg7_pattern_t SEG7_PATTERNS [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  typedef enum logic {
    ST_COLLECT = 1'b0,
    ST_PRESENT = 1'b1
  } frame_state_t;

  // Returns {1'b1, nibble} for a known pattern, 5'b0 for anything else.
  function automatic logic [4:0] seg7_decode(input seg7_pattern_t pat);
    logic [4:0] res;
    res = 5'b0;
    for (int i = 0; i < 16; i++) begin
      if (pat == SEG7_PATTERNS[i]) res = {1'b1, 4'(i)};
    end
    return res;
  endfunction

endpackage

// File: rtl/seg7_scan_decoder_if.sv
// seg7_scan_decoder_if: frame output channel of the scan decoder.
//   out_value [4*NUM_DIGITS] : frame, digit k in bits [4k+3:4k]
//   out_valid                : frame available
//   out_ready                : consumer accepts frame
//   out_dp    [NUM_DIGITS]   : decimal points (only with SEG7_SCAN_DP_EN)
//
// Handshake: a frame transfers on every clock edge where out_valid and
// out_ready are both high. Once out_valid is raised, it and the payload stay
// unchanged until that transfer (reset excepted); out_ready may change freely
// and is not required to wait for out_valid.
interface seg7_scan_decoder_if #(
  parameter int NUM_DIGITS = 4
);
  logic [4*NUM_DIGITS-1:0] out_value;
  logic                    out_valid;
  logic                    out_ready;
`ifdef SEG7_SCAN_DP_EN
  logic [NUM_DIGITS-1:0]   out_dp;

  modport master (output out_value, output out_valid, output out_dp, input out_ready);
  modport slave  (input out_value, input out_valid, input out_dp, output out_ready);
`else
  modport master (output out_value, output out_valid, input out_ready);
  modport slave  (input out_value, input out_valid, output out_ready);
`endif
endinterface

// File: rtl/seg7_digit_stabilizer.sv
// seg7_digit_stabilizer: run-length debounce of the active digit sample.
//   i_active  : exactly one digit enable is low this cycle
//   i_index   : index of that digit
//   i_seg     : synchronized active-low segment pattern
//   i_dp      : synchronized active-low decimal point (SEG7_SCAN_DP_EN only)
//   o_capture : run just reached STABLE_CYCLES with a decodable pattern
//   o_error   : run just reached STABLE_CYCLES with an undecodable pattern
//   o_nibble  : decoded value, meaningful with o_capture
//   o_index   : digit index belonging to the strobes
// Strobes are combinational so the top writes its registers on the same
// edge the counter reaches STABLE_CYCLES.
module seg7_digit_stabilizer
  import seg7_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int IDX_W         = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_active,
  input  logic [IDX_W-1:0] i_index,
  input  seg7_pattern_t    i_seg,
`ifdef SEG7_SCAN_DP_EN
  input  logic             i_dp,
`endif
  output logic             o_capture,
  output logic             o_error,
  output logic [3:0]       o_nibble,
  output logic [IDX_W-1:0] o_index
);

`ifdef SEG7_SCAN_DP_EN
  localparam int KEY_W = IDX_W + 8;
`else
  localparam int KEY_W = IDX_W + 7;
`endif
  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_PRE = CNT_W'(STABLE_CYCLES - 1);

  logic [KEY_W-1:0] w_key;
  logic [KEY_W-1:0] r_prev_key;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_count_nxt;
  logic             w_same;
  logic             w_reach;
  logic [4:0]       w_dec;

`ifdef SEG7_SCAN_DP_EN
  assign w_key = {i_index, i_seg, i_dp};
`else
  assign w_key = {i_index, i_seg};
`endif

  always_comb begin
    w_same      = (w_key == r_prev_key);
    w_count_nxt = r_count;
    if (!i_active)                w_count_nxt = '0;
    else if (!w_same)             w_count_nxt = CNT_W'(1);
    else if (r_count != CNT_MAX)  w_count_nxt = r_count + 1'b1;
    // Only the step from STABLE_CYCLES-1 to STABLE_CYCLES fires, so a long
    // steady run produces a single strobe.
    w_reach = i_active && w_same && (r_count == CNT_PRE);
    w_dec   = seg7_decode(i_seg);
  end

  assign o_capture = w_reach &&  w_dec[4];
  assign o_error   = w_reach && !w_dec[4];
  assign o_nibble  = w_dec[3:0];
  assign o_index   = i_index;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_prev_key <= '0;
      r_count    <= '0;
    end else begin
      r_prev_key <= w_key;
      r_count    <= w_count_nxt;
    end
  end

endmodule

// File: rtl/seg7_scan_decoder.sv
// seg7_scan_decoder: snoops a multiplexed active-low 7-segment bus, debounces
// each digit, decodes it to a nibble and emits complete frames.
// Optional feature macro: SEG7_SCAN_DP_EN (adds dp_n input and out_dp).
//   clk, rst     : clock, synchronous active-high reset
//   seg_n        : segments, active-low, bit0=a ... bit6=g
//   dig_n        : digit enables, active-low, one-hot-low when driven
//   dp_n         : decimal point, active-low (SEG7_SCAN_DP_EN only)
//   err_pulse    : one cycle, a stable but undecodable pattern was seen
//   err_digit    : digit index of the last error
//   o_dbg_state  : frame FSM state
//   out_if       : frame channel (out_value/out_valid/out_ready[/out_dp])
module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4,
  parameter int SYNC_STAGES   = 2,
  localparam int IDX_W        = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  seg7_pattern_t         seg_n,
  input  logic [NUM_DIGITS-1:0] dig_n,
`ifdef SEG7_SCAN_DP_EN
  input  logic                  dp_n,
`endif
  output logic                  err_pulse,
  output logic [IDX_W-1:0]      err_digit,
  output frame_state_t          o_dbg_state,
  seg7_scan_decoder_if.master   out_if
);

  localparam int LOWCNT_W = $clog2(NUM_DIGITS + 1);

  seg7_pattern_t           r_seg_sync [SYNC_STAGES];
  logic [NUM_DIGITS-1:0]   r_dig_sync [SYNC_STAGES];
  seg7_pattern_t           w_seg;
  logic [NUM_DIGITS-1:0]   w_dig;
  logic [LOWCNT_W-1:0]     w_low_cnt;
  logic [IDX_W-1:0]        w_index;
  logic                    w_active;
  logic                    w_capture;
  logic                    w_error;
  logic [3:0]              w_nibble;
  logic [IDX_W-1:0]        w_cap_index;
  logic [NUM_DIGITS-1:0]   w_set;
  logic                    w_mask_full;
  logic [3:0]              r_work [NUM_DIGITS];
  logic [4*NUM_DIGITS-1:0] w_work_flat;
  logic [NUM_DIGITS-1:0]   r_mask;
  frame_state_t            r_state;
  logic [4*NUM_DIGITS-1:0] r_out_value;
  logic                    r_out_valid;
`ifdef SEG7_SCAN_DP_EN
  logic [SYNC_STAGES-1:0]  r_dp_sync;
  logic                    w_dp;
  logic [NUM_DIGITS-1:0]   r_work_dp;
  logic [NUM_DIGITS-1:0]   r_out_dp;
`endif

  // Input synchronizers; reset to 0 (all digits low reads as blanking).
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        r_seg_sync[s] <= '0;
        r_dig_sync[s] <= '0;
      end
`ifdef SEG7_SCAN_DP_EN
      r_dp_sync <= '0;
`endif
    end else begin
      r_seg_sync[0] <= seg_n;
      r_dig_sync[0] <= dig_n;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        r_seg_sync[s] <= r_seg_sync[s-1];
        r_dig_sync[s] <= r_dig_sync[s-1];
      end
`ifdef SEG7_SCAN_DP_EN
      r_dp_sync <= {r_dp_sync[SYNC_STAGES-2:0], dp_n};
`endif
    end
  end

  assign w_seg = r_seg_sync[SYNC_STAGES-1];
  assign w_dig = r_dig_sync[SYNC_STAGES-1];
`ifdef SEG7_SCAN_DP_EN
  assign w_dp  = r_dp_sync[SYNC_STAGES-1];
`endif

  // Active only when exactly one enable is low; zero or several is blanking.
  always_comb begin
    w_low_cnt = '0;
    w_index   = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (!w_dig[k]) begin
        w_low_cnt = w_low_cnt + 1'b1;
        w_index   = IDX_W'(k);
      end
    end
    w_active = (w_low_cnt == LOWCNT_W'(1));
  end

  seg7_digit_stabilizer #(
    .STABLE_CYCLES (STABLE_CYCLES),
    .IDX_W         (IDX_W)
  ) u_stab (
    .clk       (clk),
    .rst       (rst),
    .i_active  (w_active),
    .i_index   (w_index),
    .i_seg     (w_seg),
`ifdef SEG7_SCAN_DP_EN
    .i_dp      (w_dp),
`endif
    .o_capture (w_capture),
    .o_error   (w_error),
    .o_nibble  (w_nibble),
    .o_index   (w_cap_index)
  );

  always_comb begin
    w_set = '0;
    if (w_capture) w_set[w_cap_index] = 1'b1;
    for (int k = 0; k < NUM_DIGITS; k++) w_work_flat[4*k +: 4] = r_work[k];
  end

  assign w_mask_full = &r_mask;

  // Working registers: last capture of a digit wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NUM_DIGITS; k++) r_work[k] <= '0;
`ifdef SEG7_SCAN_DP_EN
      r_work_dp <= '0;
`endif
    end else if (w_capture) begin
      r_work[w_cap_index] <= w_nibble;
`ifdef SEG7_SCAN_DP_EN
      r_work_dp[w_cap_index] <= ~w_dp;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_pulse <= 1'b0;
      err_digit <= '0;
    end else begin
      err_pulse <= w_error;
      if (w_error) err_digit <= w_cap_index;
    end
  end

  // Frame FSM. When the mask is cleared on a frame load, a capture landing
  // in the same cycle is kept as the first bit of the next frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_COLLECT;
      r_mask      <= '0;
      r_out_value <= '0;
      r_out_valid <= 1'b0;
`ifdef SEG7_SCAN_DP_EN
      r_out_dp    <= '0;
`endif
    end else begin
      r_mask <= r_mask | w_set;
      case (r_state)
        ST_COLLECT: begin
          if (w_mask_full) begin
            r_state     <= ST_PRESENT;
            r_out_value <= w_work_flat;
            r_out_valid <= 1'b1;
            r_mask      <= w_set;
`ifdef SEG7_SCAN_DP_EN
            r_out_dp    <= r_work_dp;
`endif
          end
        end
        ST_PRESENT: begin
          if (out_if.out_ready) begin
            if (w_mask_full) begin
              // Next frame already complete: swap it in without a bubble.
              r_out_value <= w_work_flat;
              r_mask      <= w_set;
`ifdef SEG7_SCAN_DP_EN
              r_out_dp    <= r_work_dp;
`endif
            end else begin
              r_state     <= ST_COLLECT;
              r_out_valid <= 1'b0;
            end
          end
        end
      endcase
    end
  end

  assign out_if.out_value = r_out_value;
  assign out_if.out_valid = r_out_valid;
`ifdef SEG7_SCAN_DP_EN
  assign out_if.out_dp    = r_out_dp;
`endif
  assign o_dbg_state      = r_state;

endmodule
